// File: rtl/gpu_cmd_queue_if.sv
// Command-queue bus: requester command channel, GPU-side field/strobe outputs and status.
// The slave modport is the queue; the master modport is the requester/GPU side.
interface gpu_cmd_queue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [31:0] cmd_address;
  logic [15:0] cmd_address_x, cmd_address_y, cmd_sheetsize, cmd_width;
  logic [15:0] cmd_height, cmd_x, cmd_y, cmd_clear_color;

  logic [31:0] gpu_address;
  logic [15:0] gpu_address_x, gpu_address_y, gpu_sheetsize, gpu_width;
  logic [15:0] gpu_height, gpu_x, gpu_y, gpu_clear_color;
  logic        gpu_draw, gpu_clear, gpu_busy;

  logic [4:0]  q_level;
  logic        idle, done;
  logic [15:0] done_count;
  logic        err_timeout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y, cmd_sheetsize,
           cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color, gpu_busy,
    output cmd_ready, gpu_address, gpu_address_x, gpu_address_y, gpu_sheetsize, gpu_width,
           gpu_height, gpu_x, gpu_y, gpu_clear_color, gpu_draw, gpu_clear,
           q_level, idle, done, done_count, err_timeout
  );

  modport master (
    output cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y, cmd_sheetsize,
           cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color, gpu_busy,
    input  cmd_ready, gpu_address, gpu_address_x, gpu_address_y, gpu_sheetsize, gpu_width,
           gpu_height, gpu_x, gpu_y, gpu_clear_color, gpu_draw, gpu_clear,
           q_level, idle, done, done_count, err_timeout
  );
endinterface

// File: rtl/gpu_cmd_queue.sv
// GPU command queue: FIFO of draw/clear commands issued one at a time to a GPU,
// with start timeout detection and a retired-command counter.
module gpu_cmd_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  gpu_cmd_queue_if.slave bus_io
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StIssue     = 3'd1;
  localparam logic [2:0] StWaitStart = 3'd2;
  localparam logic [2:0] StWaitDone  = 3'd3;
  localparam logic [2:0] StRetire    = 3'd4;

  typedef struct packed {
    logic        op;
    logic [31:0] address;
    logic [15:0] address_x;
    logic [15:0] address_y;
    logic [15:0] sheetsize;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] clear_color;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    level_q, level_d;
  logic [2:0]    state_q, state_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic [15:0]   done_count_q;
  cmd_t          cur_q;
  cmd_t          in_cmd;
  logic          push, pop;

  assign in_cmd = '{
    op:          bus_io.cmd_op,
    address:     bus_io.cmd_address,
    address_x:   bus_io.cmd_address_x,
    address_y:   bus_io.cmd_address_y,
    sheetsize:   bus_io.cmd_sheetsize,
    width:       bus_io.cmd_width,
    height:      bus_io.cmd_height,
    x:           bus_io.cmd_x,
    y:           bus_io.cmd_y,
    clear_color: bus_io.cmd_clear_color
  };

  assign bus_io.cmd_ready = (level_q < 5'(DEPTH));
  assign push    = bus_io.cmd_valid && bus_io.cmd_ready;
  // Pop only reads entries already stored, so a same-cycle push never bypasses the queue.
  assign pop     = (state_q == StIdle) && (level_q != 5'd0) && !bus_io.gpu_busy;
  assign level_d = level_q + 5'(push) - 5'(pop);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (pop) state_d = StIssue;
      end
      StIssue: begin
        state_d    = StWaitStart;
        wait_cnt_d = 2'd0;
      end
      StWaitStart: begin
        if (bus_io.gpu_busy) begin
          state_d = StWaitDone;
        end else if (wait_cnt_q == 2'd3) begin
          state_d = StRetire;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      StWaitDone: begin
        if (!bus_io.gpu_busy) state_d = StRetire;
      end
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      done_count_q <= '0;
      cur_q        <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        cur_q    <= mem_q[rd_ptr_q];
      end
      level_q    <= level_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      if (state_q == StRetire) done_count_q <= done_count_q + 16'd1;
    end
  end

  assign bus_io.gpu_address     = cur_q.address;
  assign bus_io.gpu_address_x   = cur_q.address_x;
  assign bus_io.gpu_address_y   = cur_q.address_y;
  assign bus_io.gpu_sheetsize   = cur_q.sheetsize;
  assign bus_io.gpu_width       = cur_q.width;
  assign bus_io.gpu_height      = cur_q.height;
  assign bus_io.gpu_x           = cur_q.x;
  assign bus_io.gpu_y           = cur_q.y;
  assign bus_io.gpu_clear_color = cur_q.clear_color;

  assign bus_io.gpu_draw    = (state_q == StIssue) && !cur_q.op;
  assign bus_io.gpu_clear   = (state_q == StIssue) && cur_q.op;
  assign bus_io.q_level     = level_q;
  assign bus_io.idle        = (state_q == StIdle) && (level_q == 5'd0);
  assign bus_io.done        = (state_q == StRetire);
  assign bus_io.done_count  = done_count_q;
  assign bus_io.err_timeout = err_q;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Bench for gpu_cmd_queue: directed and random commands against a cycle-level
// reference model of the queue, plus a simple GPU busy model.
module tb_gpu_cmd_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic        op;
    logic [31:0] address;
    logic [15:0] address_x;
    logic [15:0] address_y;
    logic [15:0] sheetsize;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] clear_color;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpu_cmd_queue_if bus ();
  gpu_cmd_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus_io(bus));

  // Reference model: queue contents, command in service and its lifecycle phase.
  cmd_t mq[$];
  cmd_t cur;
  int   ph;        // 0 idle, 1 strobe cycle, 2 awaiting start, 3 GPU running, 4 retire
  int   start_wait;
  int   dcnt;
  bit   err;

  // GPU model controls: mode 0 responds, 1 never starts, 2 busy held high.
  int gmode, gdelay_sel, gdur, gd, gb;
  bit last_push;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input cmd_t c);
    bus.cmd_op          = c.op;
    bus.cmd_address     = c.address;
    bus.cmd_address_x   = c.address_x;
    bus.cmd_address_y   = c.address_y;
    bus.cmd_sheetsize   = c.sheetsize;
    bus.cmd_width       = c.width;
    bus.cmd_height      = c.height;
    bus.cmd_x           = c.x;
    bus.cmd_y           = c.y;
    bus.cmd_clear_color = c.clear_color;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op          = 1'($urandom_range(0, 1));
    c.address     = $urandom;
    c.address_x   = 16'($urandom);
    c.address_y   = 16'($urandom);
    c.sheetsize   = 16'($urandom);
    c.width       = 16'($urandom);
    c.height      = 16'($urandom);
    c.x           = 16'($urandom);
    c.y           = 16'($urandom);
    c.clear_color = 16'($urandom);
    return c;
  endfunction

  task automatic tick();
    bit   push, busy;
    cmd_t c;
    logic [159:0] obs_f, exp_f;
    push = bus.cmd_valid && (mq.size() < DEPTH) && !rst;
    busy = bus.gpu_busy;
    c = '{bus.cmd_op, bus.cmd_address, bus.cmd_address_x, bus.cmd_address_y, bus.cmd_sheetsize,
          bus.cmd_width, bus.cmd_height, bus.cmd_x, bus.cmd_y, bus.cmd_clear_color};
    @(posedge clk);
    if (rst) begin
      mq.delete();
      cur = '0; ph = 0; start_wait = 0; dcnt = 0; err = 1'b0;
    end else begin
      case (ph)
        0: if (mq.size() > 0 && !busy) begin cur = mq.pop_front(); ph = 1; end
        1: begin ph = 2; start_wait = 0; end
        2: begin
          if (busy) ph = 3;
          else if (start_wait == 3) begin ph = 4; err = 1'b1; end
          else start_wait++;
        end
        3: if (!busy) ph = 4;
        default: begin ph = 0; dcnt = (dcnt + 1) % 65536; end
      endcase
      if (push) mq.push_back(c);
    end
    last_push = push;
    #1;
    chk("q_level", bus.q_level, mq.size());
    chk("cmd_ready", bus.cmd_ready, mq.size() < DEPTH);
    chk("gpu_draw", bus.gpu_draw, ph == 1 && !cur.op);
    chk("gpu_clear", bus.gpu_clear, ph == 1 && cur.op);
    chk("done", bus.done, ph == 4);
    chk("done_count", bus.done_count, dcnt);
    chk("err_timeout", bus.err_timeout, err);
    chk("idle", bus.idle, ph == 0 && mq.size() == 0);
    obs_f = {bus.gpu_address, bus.gpu_address_x, bus.gpu_address_y, bus.gpu_sheetsize,
             bus.gpu_width, bus.gpu_height, bus.gpu_x, bus.gpu_y, bus.gpu_clear_color};
    exp_f = cur[159:0];
    chk("gpu_fields", obs_f, exp_f);
    case (gmode)
      1: bus.gpu_busy = 1'b0;
      2: bus.gpu_busy = 1'b1;
      default: begin
        if (bus.gpu_draw || bus.gpu_clear) gd = gdelay_sel;
        if (gd == 0) begin gb = gdur; gd = -1; end
        else if (gd > 0) gd--;
        bus.gpu_busy = (gb > 0);
        if (gb > 0) gb--;
      end
    endcase
  endtask

  task automatic send(input cmd_t c);
    drive(c);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (last_push) break;
    end
    chk("push_accepted", last_push, 1'b1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      if (ph == 0 && mq.size() == 0) break;
      tick();
    end
    chk("drained_idle", bus.idle, 1'b1);
  endtask

  task automatic gpu_release();
    gmode = 0; gd = -1; gb = 0;
  endtask

  initial begin
    cmd_t c;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.gpu_busy  = 1'b0;
    drive('0);
    gmode = 0; gd = -1; gb = 0; gdelay_sel = 0; gdur = 16;
    cur = '0; ph = 0; start_wait = 0; dcnt = 0; err = 1'b0;

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", bus.cmd_ready, 1'b1);

    // Single draw, GPU busy for 16 cycles.
    c = '0; c.op = 1'b0; c.width = 16'd8; c.height = 16'd2; c.x = 16'd10;
    send(c);
    drain();
    chk("single_done_count", bus.done_count, 16'd1);

    // Clear command.
    c = '0; c.op = 1'b1; c.clear_color = 16'hF801; gdur = 3;
    send(c);
    drain();
    chk("clear_color", bus.gpu_clear_color, 16'hF801);

    // Fill with GPU busy, then let all five drain in order.
    gmode = 2;
    tick();
    for (int i = 0; i < 4; i++) send(rand_cmd());
    chk("fill_level", bus.q_level, 5'd4);
    chk("fill_ready", bus.cmd_ready, 1'b0);
    gpu_release();
    gdur = 2;
    send(rand_cmd());
    drain();
    chk("fill_done_count", bus.done_count, 16'd7);

    // GPU never starts: two timeouts, then a normal command.
    gmode = 1;
    send(rand_cmd());
    send(rand_cmd());
    drain();
    chk("timeout_err", bus.err_timeout, 1'b1);
    gpu_release();
    send(rand_cmd());
    drain();
    chk("post_timeout_count", bus.done_count, 16'd10);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      gdelay_sel = $urandom_range(0, 2);
      gdur = $urandom_range(1, 8);
      send(rand_cmd());
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();

    // Reset while the GPU runs with two commands queued.
    gdelay_sel = 0; gdur = 40;
    for (int i = 0; i < 3; i++) send(rand_cmd());
    for (int i = 0; i < 100; i++) begin
      if (ph == 3) break;
      tick();
    end
    chk("pre_rst_level", bus.q_level, 5'd2);
    gmode = 2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gd = -1; gb = 0;
    chk("rst_level", bus.q_level, 5'd0);
    chk("rst_address", bus.gpu_address, 32'd0);
    repeat (3) tick();
    send(rand_cmd());
    repeat (6) tick();
    chk("held_queued", bus.q_level, 5'd1);
    gpu_release();
    gdur = 2;
    drain();
    chk("post_rst_count", bus.done_count, 16'd1);

    // Counter wrap from a forced 0xFFFF.
    force dut.done_count_q = 16'hFFFF;
    dcnt = 65535;
    tick();
    release dut.done_count_q;
    tick();
    send(rand_cmd());
    drain();
    chk("wrap_count", bus.done_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
